mic_dma_nch: RTL and testbench

Parametrised N-channel microphone capture DMA, the next generation of the fixed five-channel mic writer. On each sample-ready strobe it walks every channel through the mic mux (select) and issues one Avalon-MM single-beat write per channel into per-channel contiguous buffers in SDRAM. Channel count and widths are generic. The block adds zero-length handling and a sticky overrun flag, and uses a single address-computation path instead of per-channel registers. It sits between the mic front-end mux and the HPS/SDRAM interconnect, controlled by the CSR slave (start, address, sample count, FINISHED).

---
 rtl/mic_dma_nch_if.sv | 22 ++
 rtl/mic_dma_nch.sv | 156 +++++++++++++++
 tb/tb_mic_dma_nch.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mic_dma_nch_if.sv
// Avalon-MM single-beat write master bundle used by the mic capture DMA.
interface mic_dma_nch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   AM_ADDR;
  logic [2:0]          AM_BURSTCOUNT;
  logic                AM_WRITE;
  logic [DATA_W-1:0]   AM_WRITEDATA;
  logic [DATA_W/8-1:0] AM_BYTEENABLE;
  logic                AM_WAITREQUEST;

  modport master (
    output AM_ADDR, AM_BURSTCOUNT, AM_WRITE, AM_WRITEDATA, AM_BYTEENABLE,
    input  AM_WAITREQUEST
  );

  modport slave (
    input  AM_ADDR, AM_BURSTCOUNT, AM_WRITE, AM_WRITEDATA, AM_BYTEENABLE,
    output AM_WAITREQUEST
  );
endinterface

// File: rtl/mic_dma_nch.sv
// N-channel mic capture DMA: per read_ready frame, walks every channel through the
// mic mux and writes one sample per channel into its contiguous SDRAM buffer.
module mic_dma_nch #(
  parameter int unsigned NUM_CH   = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned SEL_BASE = 1
) (
  input  logic                CLK,
  input  logic                RESET,
  mic_dma_nch_if.master       am,
  input  logic [DATA_W-1:0]   mic_data,
  output logic [2:0]          select,
  input  logic                read_ready,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_address,
  input  logic [CNT_W-1:0]    number_samples,
  output logic                FINISHED,
  output logic                BUSY,
  output logic                OVERRUN
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    SETTLE,
    WRITE,
    FIN
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  nsamp_q;
  logic [CNT_W-1:0]  s_q;
  logic [CH_W-1:0]   c_q;
  logic [2:0]        sel_q;
  logic              write_q;
  logic              fin_q;
  logic              busy_q;
  logic              ovr_q;

  logic [ADDR_W-1:0] addr_c;
  logic              last_ch_c;
  logic              last_samp_c;

  // Single shared address path: base + c*stride + s*BYTES, wrapping mod 2^ADDR_W.
  assign addr_c      = base_q + ADDR_W'(c_q) * stride_q + ADDR_W'(s_q) * ADDR_W'(BYTES);
  assign last_ch_c   = (c_q == CH_W'(NUM_CH - 1));
  assign last_samp_c = ((s_q + CNT_W'(1)) == nsamp_q);

  assign am.AM_ADDR        = addr_q;
  assign am.AM_BURSTCOUNT  = 3'd1;
  assign am.AM_WRITE       = write_q;
  assign am.AM_WRITEDATA   = mic_data;
  assign am.AM_BYTEENABLE  = '1;
  assign select            = sel_q;
  assign FINISHED          = fin_q;
  assign BUSY              = busy_q;
  assign OVERRUN           = ovr_q;

  // Capture sequencer; select is 3 bits wide, so codes above 7 wrap.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      base_q   <= '0;
      stride_q <= '0;
      addr_q   <= '0;
      nsamp_q  <= '0;
      s_q      <= '0;
      c_q      <= '0;
      sel_q    <= 3'(SEL_BASE);
      write_q  <= 1'b0;
      fin_q    <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          write_q <= 1'b0;
          if (start) begin
            base_q   <= start_address;
            nsamp_q  <= number_samples;
            stride_q <= ADDR_W'(number_samples) * ADDR_W'(BYTES);
            s_q      <= '0;
            c_q      <= '0;
            ovr_q    <= 1'b0;
            if (number_samples == '0) begin
              state_q <= FIN;
              fin_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= WAIT_FRAME;
              fin_q   <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end

        WAIT_FRAME: begin
          write_q <= 1'b0;
          if (read_ready) begin
            c_q     <= '0;
            sel_q   <= 3'(SEL_BASE);
            state_q <= SETTLE;
          end
        end

        SETTLE: begin
          if (read_ready) ovr_q <= 1'b1;
          write_q <= 1'b1;
          addr_q  <= addr_c;
          state_q <= WRITE;
        end

        WRITE: begin
          if (read_ready) ovr_q <= 1'b1;
          if (!am.AM_WAITREQUEST) begin
            write_q <= 1'b0;
            if (!last_ch_c) begin
              c_q     <= c_q + CH_W'(1);
              sel_q   <= sel_q + 3'd1;
              state_q <= SETTLE;
            end else begin
              s_q <= s_q + CNT_W'(1);
              if (last_samp_c) begin
                state_q <= FIN;
                fin_q   <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q <= WAIT_FRAME;
              end
            end
          end
        end

        FIN: begin
          write_q <= 1'b0;
          fin_q   <= 1'b1;
          if (!start) state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          write_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mic_dma_nch.sv
// Directed bench for mic_dma_nch: a 5-channel/32-bit instance and an 8-channel/16-bit
// instance, with expected writes queued per frame and popped as writes are accepted.
module tb_mic_dma_nch;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  sel;
    logic [31:0] data;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        rr;
  logic        start_a, start_b;
  logic [31:0] cfg_addr;
  logic [31:0] cfg_n;
  logic        wr;
  logic        which;

  logic [31:0] mic_a;
  logic [15:0] mic_b;
  logic [2:0]  sel_a, sel_b;
  logic        fin_a, busy_a, ovr_a;
  logic        fin_b, busy_b, ovr_b;

  logic        mon_write;
  logic [31:0] mon_addr;
  logic [2:0]  mon_sel;
  logic [31:0] mon_data;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  mic_dma_nch_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
  mic_dma_nch_if #(.ADDR_W(32), .DATA_W(16)) ifb ();

  mic_dma_nch #(.NUM_CH(5), .DATA_W(32), .ADDR_W(32), .CNT_W(32), .SEL_BASE(1)) dut_a (
    .CLK(CLK), .RESET(RESET), .am(ifa.master), .mic_data(mic_a), .select(sel_a),
    .read_ready(rr), .start(start_a), .start_address(cfg_addr), .number_samples(cfg_n),
    .FINISHED(fin_a), .BUSY(busy_a), .OVERRUN(ovr_a)
  );

  mic_dma_nch #(.NUM_CH(8), .DATA_W(16), .ADDR_W(32), .CNT_W(32), .SEL_BASE(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .am(ifb.master), .mic_data(mic_b), .select(sel_b),
    .read_ready(rr), .start(start_b), .start_address(cfg_addr), .number_samples(cfg_n),
    .FINISHED(fin_b), .BUSY(busy_b), .OVERRUN(ovr_b)
  );

  // Mic mux model: sample value encodes the selected channel.
  assign mic_a = 32'hA5A5_0000 | 32'(sel_a);
  assign mic_b = 16'hB000 | 16'(sel_b);

  assign ifa.AM_WAITREQUEST = which ? 1'b0 : wr;
  assign ifb.AM_WAITREQUEST = which ? wr : 1'b0;

  assign mon_write = which ? ifb.AM_WRITE : ifa.AM_WRITE;
  assign mon_addr  = which ? ifb.AM_ADDR  : ifa.AM_ADDR;
  assign mon_sel   = which ? sel_b        : sel_a;
  assign mon_data  = which ? 32'(ifb.AM_WRITEDATA) : ifa.AM_WRITEDATA;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_frame(input int s, input int nch, input logic [31:0] base,
                            input int bytes, input int stride);
    exp_t e;
    for (int c = 0; c < nch; c++) begin
      e.addr = 32'(64'(base) + 64'(c) * 64'(stride) + 64'(s) * 64'(bytes));
      e.sel  = 3'(1 + c);
      e.data = which ? 32'(16'hB000 | 16'(e.sel)) : (32'hA5A5_0000 | 32'(e.sel));
      sb.push_back(e);
    end
  endtask

  task automatic pulse_rr();
    @(negedge CLK); rr = 1'b1;
    @(negedge CLK); rr = 1'b0;
  endtask

  // Accept n writes; write number stall_idx is held off for stall_len cycles.
  task automatic collect(input string tag, input int n, input int stall_idx, input int stall_len);
    int          got    = 0;
    int          budget = 0;
    int          stalls = 0;
    logic [31:0] a0     = '0;
    logic [2:0]  s0     = '0;
    exp_t        e;
    while (got < n && budget < 2000) begin
      @(negedge CLK);
      budget++;
      if (mon_write && got == stall_idx && stalls < stall_len) begin
        if (stalls == 0) begin
          a0 = mon_addr;
          s0 = mon_sel;
        end else begin
          chk($sformatf("%s_stall_addr%0d", tag, stalls), 64'(mon_addr), 64'(a0));
          chk($sformatf("%s_stall_sel%0d", tag, stalls), 64'(mon_sel), 64'(s0));
        end
        stalls++;
        wr = 1'b1;
      end else if (mon_write) begin
        wr = 1'b0;
        if (sb.size() == 0) begin
          chk($sformatf("%s_sb_empty%0d", tag, got), 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          chk($sformatf("%s_addr%0d", tag, got), 64'(mon_addr), 64'(e.addr));
          chk($sformatf("%s_sel%0d", tag, got), 64'(mon_sel), 64'(e.sel));
          chk($sformatf("%s_data%0d", tag, got), 64'(mon_data), 64'(e.data));
        end
        got++;
      end else begin
        wr = 1'b0;
      end
    end
    wr = 1'b0;
    chk({tag, "_count"}, 64'(got), 64'(n));
    if (stall_idx >= 0) chk({tag, "_stalls"}, 64'(stalls), 64'(stall_len));
  endtask

  task automatic count_writes(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      if (mon_write) n++;
    end
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_write"}, 64'(ifa.AM_WRITE), 64'(0));
    chk({tag, "_addr"},  64'(ifa.AM_ADDR), 64'(0));
    chk({tag, "_sel"},   64'(sel_a), 64'(1));
    chk({tag, "_fin"},   64'(fin_a), 64'(0));
    chk({tag, "_busy"},  64'(busy_a), 64'(0));
    chk({tag, "_ovr"},   64'(ovr_a), 64'(0));
    chk({tag, "_burst"}, 64'(ifa.AM_BURSTCOUNT), 64'(1));
    chk({tag, "_be"},    64'(ifa.AM_BYTEENABLE), 64'(4'hF));
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RESET = 1'b1; rr = 1'b0; start_a = 1'b0; start_b = 1'b0;
    cfg_addr = '0; cfg_n = '0; wr = 1'b0; which = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check_reset_a("rst_a");
    chk("rst_b_sel", 64'(sel_b), 64'(1));
    chk("rst_b_be", 64'(ifb.AM_BYTEENABLE), 64'(2'h3));
    chk("rst_b_fin", 64'(fin_b), 64'(0));

    // Zero-length capture goes straight to FIN with no writes.
    cfg_addr = 32'h0000_1000; cfg_n = 32'd0; start_a = 1'b1;
    @(negedge CLK);
    chk("zero_fin", 64'(fin_a), 64'(1));
    chk("zero_busy", 64'(busy_a), 64'(0));
    count_writes(6, n);
    chk("zero_writes", 64'(n), 64'(0));
    start_a = 1'b0;
    @(negedge CLK);

    // Two frames, five channels, no stalls.
    cfg_addr = 32'h0000_1000; cfg_n = 32'd2; start_a = 1'b1;
    @(negedge CLK);
    chk("t1_busy", 64'(busy_a), 64'(1));
    chk("t1_fin_cleared", 64'(fin_a), 64'(0));
    for (int s = 0; s < 2; s++) begin
      push_frame(s, 5, 32'h0000_1000, 4, 8);
      pulse_rr();
      collect($sformatf("t1_s%0d", s), 5, -1, 0);
    end
    @(negedge CLK);
    chk("t1_fin", 64'(fin_a), 64'(1));
    chk("t1_busy_done", 64'(busy_a), 64'(0));
    start_a = 1'b0;
    repeat (2) @(negedge CLK);
    chk("t1_fin_held_idle", 64'(fin_a), 64'(1));

    // Channel 2 write stalled for 7 cycles.
    cfg_addr = 32'h0000_3000; cfg_n = 32'd1; start_a = 1'b1;
    @(negedge CLK);
    push_frame(0, 5, 32'h0000_3000, 4, 4);
    pulse_rr();
    collect("stall", 5, 2, 7);
    @(negedge CLK);
    chk("stall_fin", 64'(fin_a), 64'(1));
    start_a = 1'b0;
    repeat (2) @(negedge CLK);

    // Extra read_ready mid-frame sets OVERRUN but the frame completes normally.
    cfg_addr = 32'h0000_4000; cfg_n = 32'd1; start_a = 1'b1;
    @(negedge CLK);
    chk("ovr_busy", 64'(busy_a), 64'(1));
    chk("ovr_pre", 64'(ovr_a), 64'(0));
    push_frame(0, 5, 32'h0000_4000, 4, 4);
    pulse_rr();
    fork
      collect("ovr", 5, -1, 0);
      begin
        repeat (2) @(negedge CLK);
        rr = 1'b1;
        @(negedge CLK);
        rr = 1'b0;
      end
    join
    @(negedge CLK);
    chk("ovr_flag", 64'(ovr_a), 64'(1));
    chk("ovr_fin", 64'(fin_a), 64'(1));
    chk("ovr_sb_empty", 64'(sb.size()), 64'(0));
    start_a = 1'b0;
    repeat (2) @(negedge CLK);
    cfg_addr = 32'h0000_5000; start_a = 1'b1;
    @(negedge CLK);
    chk("ovr_cleared", 64'(ovr_a), 64'(0));

    // Reset while a write is stalled.
    wr = 1'b1;
    pulse_rr();
    n = 0;
    while (!mon_write && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("rst_stall_reached", 64'(mon_write), 64'(1));
    RESET = 1'b1; start_a = 1'b0;
    @(negedge CLK);
    check_reset_a("rst_mid");
    RESET = 1'b0; wr = 1'b0;
    sb.delete();
    pulse_rr();
    count_writes(30, n);
    chk("rst_no_writes", 64'(n), 64'(0));
    chk("rst_busy_after", 64'(busy_a), 64'(0));

    // Eight channels, 16-bit samples, buffers wrapping through address 0.
    which = 1'b1;
    cfg_addr = 32'hFFFF_FFF0; cfg_n = 32'd3; start_b = 1'b1;
    @(negedge CLK);
    chk("w_busy", 64'(busy_b), 64'(1));
    for (int s = 0; s < 3; s++) begin
      push_frame(s, 8, 32'hFFFF_FFF0, 2, 6);
      pulse_rr();
      collect($sformatf("w_s%0d", s), 8, -1, 0);
    end
    @(negedge CLK);
    chk("w_fin", 64'(fin_b), 64'(1));
    chk("w_ovr", 64'(ovr_b), 64'(0));
    start_b = 1'b0;
    repeat (2) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
